// File: rtl/arb_rr2.sv
// -----------------------------------------------------------------------------
// arb_rr2 -- two-source round-robin arbiter with a one-word output register.
//
// Purpose
//   Merges two valid/ready sources (A and B) into a single registered output
//   word. The output register is a two-state machine (EMPTY/FULL). When both
//   sources offer a word on a load cycle, the source that did not win last
//   time gets the grant, so neither source can starve.
//
// Ports
//   Clk          in   clock, all state updates on the rising edge
//   Rst          in   synchronous active-high reset
//   a / a_valid  in   source A data / A offers a word
//   a_ready      out  A word accepted this cycle (combinational)
//   b / b_valid  in   source B data / B offers a word
//   b_ready      out  B word accepted this cycle (combinational)
//   d            out  registered arbitrated word
//   sel          out  source tag of d (0 = A, 1 = B)
//   d_valid      out  d holds a word
//   d_ready      in   consumer takes d this cycle
//   o_dbg_state  out  current FSM state (0 = EMPTY, 1 = FULL)
//   o_dbg_last   out  round-robin pointer (source of most recent grant)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Sources must hold data and valid stable until their ready is
// seen; ready never depends on anything the source changes after valid.
// The consumer side follows the same rule with d_valid/d_ready.
// -----------------------------------------------------------------------------
module arb_rr2 #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] a,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [DATAWIDTH-1:0] b,
    input  logic                 b_valid,
    output logic                 b_ready,
    output logic [DATAWIDTH-1:0] d,
    output logic                 sel,
    output logic                 d_valid,
    input  logic                 d_ready,
    output logic                 o_dbg_state,
    output logic                 o_dbg_last
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_last;
    logic [DATAWIDTH-1:0]   r_d;
    logic                   r_sel;

    logic                   w_load;
    logic                   w_grant_a;
    logic                   w_grant_b;

    // The output slot can take a new word when it is empty or is being
    // drained this cycle. Reset blocks any acceptance.
    assign w_load = !Rst && ((r_state == S_EMPTY) || d_ready);

    // On a tie, r_last == 1 means B won last, so A goes next (and vice versa).
    assign w_grant_a = w_load && a_valid && (!b_valid || r_last);
    assign w_grant_b = w_load && b_valid && (!a_valid || !r_last);

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (w_grant_a || w_grant_b) begin
            w_next_state = S_FULL;
        end else if (w_load) begin
            // Drained (or already empty) with nothing to take in.
            w_next_state = S_EMPTY;
        end
    end

    // Output logic
    always_comb begin
        a_ready     = w_grant_a;
        b_ready     = w_grant_b;
        d_valid     = (r_state == S_FULL);
        d           = r_d;
        sel         = r_sel;
        o_dbg_state = r_state;
        o_dbg_last  = r_last;
    end

    // Datapath: word, tag and round-robin pointer only move on a grant, so
    // they hold their values across a stall and after the slot drains.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_d    <= '0;
            r_sel  <= 1'b0;
            r_last <= 1'b1;
        end else if (w_grant_a) begin
            r_d    <= a;
            r_sel  <= 1'b0;
            r_last <= 1'b0;
        end else if (w_grant_b) begin
            r_d    <= b;
            r_sel  <= 1'b1;
            r_last <= 1'b1;
        end
    end

endmodule

// File: tb/tb_arb_rr2.sv
module tb_arb_rr2;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Rst;
    logic [W-1:0] a;
    logic         a_valid;
    logic         a_ready;
    logic [W-1:0] b;
    logic         b_valid;
    logic         b_ready;
    logic [W-1:0] d;
    logic         sel;
    logic         d_valid;
    logic         d_ready;
    logic         o_dbg_state;
    logic         o_dbg_last;

    arb_rr2 #(.DATAWIDTH(W)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .a           (a),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .b           (b),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .d           (d),
        .sel         (sel),
        .d_valid     (d_valid),
        .d_ready     (d_ready),
        .o_dbg_state (o_dbg_state),
        .o_dbg_last  (o_dbg_last)
    );

    // ---------------- clock ----------------
    always #5 Clk = ~Clk;

    // ---------------- scoreboard / model state ----------------
    int           checks = 0;
    int           errors = 0;
    logic [W:0]   exp_q[$];          // {sel, data} of accepted words
    logic         m_known;
    logic         m_full;
    logic         m_last;
    logic         m_sel;
    logic [W-1:0] m_d;
    logic         g_ga;
    logic         g_gb;
    logic         prev_tie;
    logic         prev_src;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the falling edge, check against the model just
    // after, then advance the model to what the next rising edge produces.
    task automatic cycle(input logic rst, input logic av, input logic [W-1:0] ad,
                         input logic bv, input logic [W-1:0] bd, input logic dr);
        logic       load;
        logic       ga;
        logic       gb;
        logic       tie;
        logic [W:0] front;
        @(negedge Clk);
        Rst     = rst;
        a_valid = av;
        a       = ad;
        b_valid = bv;
        b       = bd;
        d_ready = dr;
        #1;
        if (m_known) begin
            chk("d_valid", 64'(d_valid), 64'(m_full));
            chk("state",   64'(o_dbg_state), 64'(m_full));
            chk("last",    64'(o_dbg_last), 64'(m_last));
            chk("d",       64'(d), 64'(m_d));
            chk("sel",     64'(sel), 64'(m_sel));
        end
        load = !rst && (!m_full || dr);
        ga   = load && av && (!bv || m_last);
        gb   = load && bv && (!av || !m_last);
        chk("a_ready", 64'(a_ready), 64'(ga));
        chk("b_ready", 64'(b_ready), 64'(gb));
        chk("ready_onehot", 64'(a_ready && b_ready), 64'(0));
        // Consecutive tied loads must alternate sources.
        tie = load && av && bv;
        if (tie && prev_tie) chk("starve", 64'(b_ready), 64'(!prev_src));
        prev_tie = tie;
        prev_src = b_ready;
        // Consumer takes the held word: it must be the oldest accepted one.
        if (!rst && m_known && m_full && dr) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_empty observed=%0h expected=none", {sel, d});
            end else begin
                front = exp_q.pop_front();
                chk("sb_word", 64'({sel, d}), 64'(front));
            end
        end
        if (rst) exp_q.delete();
        else if (ga || gb) exp_q.push_back(gb ? {1'b1, bd} : {1'b0, ad});
        if (rst) begin
            m_full  = 1'b0;
            m_d     = '0;
            m_sel   = 1'b0;
            m_last  = 1'b1;
            m_known = 1'b1;
        end else if (ga || gb) begin
            m_full = 1'b1;
            m_d    = gb ? bd : ad;
            m_sel  = gb;
            m_last = gb;
        end else if (load) begin
            m_full = 1'b0;
        end
        g_ga = ga;
        g_gb = gb;
    endtask

    // Move just past the rising edge to look at registered results.
    task automatic post();
        @(posedge Clk);
        #1;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic         a_pend;
        logic         b_pend;
        logic [W-1:0] a_dat;
        logic [W-1:0] b_dat;
        logic         dr;
        Rst = 1'b1; a = '0; a_valid = 1'b0; b = '0; b_valid = 1'b0; d_ready = 1'b0;
        m_known = 1'b0; m_full = 1'b0; m_last = 1'b1; m_sel = 1'b0; m_d = '0;
        prev_tie = 1'b0; prev_src = 1'b0; g_ga = 1'b0; g_gb = 1'b0;

        // Reset state, with inputs offered to show nothing is accepted.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 1, 32'h42, 1, 32'h43, 1);
        post();
        chk("rst_dvalid", 64'(d_valid), 64'(0));
        chk("rst_d",      64'(d), 64'(0));
        chk("rst_sel",    64'(sel), 64'(0));
        chk("rst_last",   64'(o_dbg_last), 64'(1));

        // Single A word: 1-cycle latency, then drains.
        cycle(0, 1, 32'h11, 0, 0, 1);
        chk("t30_aready", 64'(a_ready), 64'(1));
        post();
        chk("t30_d",      64'(d), 64'(32'h11));
        chk("t30_sel",    64'(sel), 64'(0));
        chk("t30_dvalid", 64'(d_valid), 64'(1));
        cycle(0, 0, 0, 0, 0, 1);
        post();
        chk("t30_drain",  64'(d_valid), 64'(0));
        chk("t30_dhold",  64'(d), 64'(32'h11));

        // Continuous tie from reset: A,B,A,B.
        cycle(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 1, 32'hA, 1, 32'hB, 1);
            post();
            chk("t31_d",   64'(d), (k % 2 == 1) ? 64'hB : 64'hA);
            chk("t31_sel", 64'(sel), 64'(k % 2));
        end

        // Stall with B waiting.
        cycle(0, 1, 32'h5, 0, 0, 1);
        post();
        chk("t32_d5", 64'(d), 64'h5);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 1, 32'h99, 0);
            chk("t32_bstall", 64'(b_ready), 64'(0));
            post();
            chk("t32_dhold", 64'(d), 64'h5);
        end
        cycle(0, 0, 0, 1, 32'h99, 1);
        chk("t32_bacc", 64'(b_ready), 64'(1));
        post();
        chk("t32_db",   64'(d), 64'h99);
        chk("t32_selb", 64'(sel), 64'(1));

        // B only for 4 cycles, then a tie goes to A.
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 1, 32'h30 + 32'(k), 1);
            chk("t33_bready", 64'(b_ready), 64'(1));
            post();
            chk("t33_dvalid", 64'(d_valid), 64'(1));
            chk("t33_last",   64'(o_dbg_last), 64'(1));
        end
        cycle(0, 1, 32'hA1, 1, 32'hB1, 1);
        chk("t33_tie_a", 64'(a_ready), 64'(1));
        post();
        chk("t33_sel", 64'(sel), 64'(0));
        chk("t33_d",   64'(d), 64'hA1);

        // Reset while FULL beats a simultaneous accept.
        cycle(0, 1, 32'h77, 0, 0, 1);
        post();
        chk("t34_d77", 64'(d), 64'h77);
        cycle(1, 1, 32'h88, 1, 32'h99, 1);
        chk("t34_ardy", 64'(a_ready), 64'(0));
        chk("t34_brdy", 64'(b_ready), 64'(0));
        post();
        chk("t34_dvalid", 64'(d_valid), 64'(0));
        chk("t34_d",      64'(d), 64'(0));
        chk("t34_sel",    64'(sel), 64'(0));
        cycle(0, 1, 32'hC, 1, 32'hD, 1);
        chk("t34_tie_a", 64'(a_ready), 64'(1));
        post();
        chk("t34_sel_a", 64'(sel), 64'(0));

        // Random traffic; sources hold their word until accepted.
        a_pend = 1'b0; b_pend = 1'b0; a_dat = '0; b_dat = '0;
        for (int n = 0; n < 10000; n++) begin
            if (!a_pend && $urandom_range(0, 1) == 1) begin
                a_pend = 1'b1;
                a_dat  = $urandom;
            end
            if (!b_pend && $urandom_range(0, 1) == 1) begin
                b_pend = 1'b1;
                b_dat  = $urandom;
            end
            dr = ($urandom_range(0, 3) != 0);
            cycle(0, a_pend, a_dat, b_pend, b_dat, dr);
            if (g_ga) a_pend = 1'b0;
            if (g_gb) b_pend = 1'b0;
        end

        // Drain: every accepted word must have been delivered.
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 1);
        chk("sb_drain", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_rr2.md
ARB_RR2 -- requirements
Module: arb_rr2

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 32, giving the width of a, b and d.
REQ-002 The block SHALL have port Clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port a, input, DATAWIDTH bits, source A data.
REQ-005 The block SHALL have port a_valid, input, 1 bit, source A offers a word.
REQ-006 The block SHALL have port a_ready, output, 1 bit, source A word accepted this cycle.
REQ-007 The block SHALL have port b, input, DATAWIDTH bits, source B data.
REQ-008 The block SHALL have port b_valid, input, 1 bit, source B offers a word.
REQ-009 The block SHALL have port b_ready, output, 1 bit, source B word accepted this cycle.
REQ-010 The block SHALL have port d, output, DATAWIDTH bits, registered arbitrated word.
REQ-011 The block SHALL have port sel, output, 1 bit, source tag of d (0 = A, 1 = B), in MUX2x1 select encoding.
REQ-012 The block SHALL have port d_valid, output, 1 bit, d holds a word.
REQ-013 The block SHALL have port d_ready, input, 1 bit, consumer takes d this cycle.

Function
REQ-014 The block SHALL hold one output word in a two-state machine: EMPTY (d_valid=0) and FULL (d_valid=1).
REQ-015 The block SHALL define load = EMPTY or (FULL and d_ready); no load SHALL occur otherwise.
REQ-016 The block SHALL keep a 1-bit pointer last that records the source of the most recent grant.
REQ-017 On load, if only a_valid is high, the block SHALL grant A; if only b_valid is high, it SHALL grant B.
REQ-018 On load with both valid, the block SHALL grant the source not equal to last (round-robin).
REQ-019 a_ready and b_ready SHALL be combinational, one-hot-or-zero, and high only for the granted source on a load cycle.
REQ-020 On a grant, the next Clk edge SHALL set d to the granted data, sel to the granted tag, last to the granted tag, and the state to FULL.
REQ-021 Latency from accepted input to d_valid SHALL be exactly 1 cycle; sustained throughput SHALL be 1 word per cycle while d_ready=1.
REQ-022 In FULL with d_ready=1 and no valid input, the next state SHALL be EMPTY; d and sel SHALL keep their last values.
REQ-023 In FULL with d_ready=0, d, sel, d_valid and last SHALL remain unchanged and both readies SHALL be 0.
REQ-024 A source not granted SHALL not lose its word; the block relies on the source holding a/a_valid (or b/b_valid) until its ready.
REQ-025 With neither valid on a load cycle, last SHALL be unchanged.
REQ-026 Starvation bound: with both sources continuously valid and d_ready=1, each source SHALL be granted at least once every 2 cycles.

Reset
REQ-027 When Rst=1 at a Clk edge, the block SHALL go to EMPTY with d_valid=0, d=0, sel=0, and last=1 (so A wins the first tie).
REQ-028 While Rst=1, a_ready and b_ready SHALL be 0 and no word SHALL be accepted.
REQ-029 Rst asserted while FULL SHALL discard the held word; Rst has priority over every simultaneous event.

Verification
REQ-030 Reset, then a=0x11 a_valid=1 for one cycle, d_ready=1 -> a_ready=1 that cycle; next cycle d=0x11, sel=0, d_valid=1; following cycle d_valid=0.
REQ-031 Both valid continuously (a=0xA, b=0xB), d_ready=1, from reset -> grants A,B,A,B; d sequence 0xA,0xB,0xA,0xB with sel 0,1,0,1.
REQ-032 FULL with d=0x5, d_ready=0 for 3 cycles while b_valid=1 -> b_ready=0, d=0x5 stable; d_ready=1 -> b accepted same cycle, next d=b, sel=1.
REQ-033 Only b_valid=1 for 4 cycles, d_ready=1 -> b_ready=1 every cycle, throughput 1/cycle, last=1; then tie -> A granted.
REQ-034 Rst pulsed while FULL (d=0x77) -> next cycle d_valid=0, d=0, sel=0; a subsequent tie grants A.
REQ-035 Random a_valid/b_valid/d_ready for 10000 cycles -> scoreboard: no word lost or duplicated, readies never both high, starvation bound of REQ-026 holds.
